// File: rtl/buzzer_pkg.sv
// Shared buzzer/tone constants: base half-period table, octave rule, decoder defaults.
package buzzer_pkg;

    localparam int unsigned CNT_W             = 21;
    localparam int unsigned TIMEOUT_DEFAULT   = 1_600_000;
    localparam int unsigned TOL_SHIFT_DEFAULT = 6;

    typedef logic [CNT_W-1:0] half_period_t;
    typedef logic [4:0]       entry_t;

    localparam entry_t LAST_ENTRY = 5'd20;

    typedef enum logic [1:0] {
        OCT_DOWN,
        OCT_BASE,
        OCT_UP
    } octave_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } dec_state_e;

    // Half-periods in 100 MHz cycles for do..si of the base octave.
    function automatic half_period_t base_half_period(input logic [2:0] n);
        case (n)
            3'd0:    return half_period_t'(381680);
            3'd1:    return half_period_t'(340136);
            3'd2:    return half_period_t'(303030);
            3'd3:    return half_period_t'(285714);
            3'd4:    return half_period_t'(255102);
            3'd5:    return half_period_t'(227273);
            3'd6:    return half_period_t'(202429);
            default: return '0;
        endcase
    endfunction

    function automatic half_period_t octave_shift(input half_period_t base, input octave_e oct);
        case (oct)
            OCT_DOWN: return base << 1;
            OCT_UP:   return base >> 1;
            default:  return base;
        endcase
    endfunction

    // Table entries are ordered octave_down do..si, base do..si, octave_up do..si.
    function automatic octave_e entry_octave(input entry_t e);
        if (e < 5'd7)
            return OCT_DOWN;
        else if (e < 5'd14)
            return OCT_BASE;
        else
            return OCT_UP;
    endfunction

    function automatic logic [2:0] entry_note_idx(input entry_t e);
        entry_t n;
        n = e;
        if (e >= 5'd14)
            n = e - 5'd14;
        else if (e >= 5'd7)
            n = e - 5'd7;
        return 3'(n);
    endfunction

    function automatic logic [3:0] entry_note(input entry_t e);
        return {1'b0, entry_note_idx(e)} + 4'd1;
    endfunction

    function automatic half_period_t ref_half_period(input entry_t e, input int unsigned scale_shift);
        return octave_shift(base_half_period(entry_note_idx(e)), entry_octave(e)) >> scale_shift;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a both-edges detector.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic edge_pulse
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            sr <= '0;
        else
            sr <= {sr[1:0], d};
    end

    assign edge_pulse = sr[2] ^ sr[1];

endmodule

// File: rtl/tone_decoder.sv
// Decodes a buzzer-style square wave into note/octave by measuring half-periods
// and searching the shared reference table with a single comparator.
module tone_decoder
    import buzzer_pkg::*;
#(
    parameter int unsigned TOL_SHIFT    = TOL_SHIFT_DEFAULT,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEFAULT,
    // Divides every reference half-period; 0 for real tones, non-zero for fast sims.
    parameter int unsigned PERIOD_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_in,
    output logic [3:0] note,
    output logic       octave_up,
    output logic       octave_down,
    output logic       en,
    output logic       note_valid
);

    localparam half_period_t TIMEOUT_CNT = half_period_t'(TIMEOUT);

    logic         edge_pulse;
    half_period_t cnt;
    half_period_t cap;
    half_period_t ref_val;
    half_period_t ref_tol;
    half_period_t diff;
    entry_t       idx;
    entry_t       cand_idx;
    logic [1:0]   hits;
    dec_state_e   state;
    dec_state_e   state_next;

    logic         cnt_sat;
    logic         timeout_hit;
    logic         capture_take;
    logic         match;
    logic         last_idx;
    logic [3:0]   cand_note;
    logic         cand_up;
    logic         cand_down;
    logic         cand_new;

    sync_edge u_sync_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (tone_in),
        .edge_pulse (edge_pulse)
    );

    always_comb begin
        cnt_sat      = (cnt == TIMEOUT_CNT);
        timeout_hit  = !edge_pulse && (cnt == TIMEOUT_CNT - half_period_t'(1));
        capture_take = edge_pulse && !cnt_sat && (state == ST_IDLE);

        ref_val  = ref_half_period(idx, PERIOD_SHIFT);
        ref_tol  = ref_val >> TOL_SHIFT;
        diff     = (cap >= ref_val) ? (cap - ref_val) : (ref_val - cap);
        match    = (diff <= ref_tol);
        last_idx = (idx == LAST_ENTRY);

        cand_note = entry_note(cand_idx);
        cand_up   = (entry_octave(cand_idx) == OCT_UP);
        cand_down = (entry_octave(cand_idx) == OCT_DOWN);
        cand_new  = {cand_note, cand_up, cand_down, 1'b1} != {note, octave_up, octave_down, en};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (capture_take) state_next = ST_SEARCH;
            ST_SEARCH: if (match || last_idx) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= TIMEOUT_CNT;
            cap         <= '0;
            idx         <= '0;
            cand_idx    <= '0;
            hits        <= '0;
            note        <= '0;
            octave_up   <= 1'b0;
            octave_down <= 1'b0;
            en          <= 1'b0;
            note_valid  <= 1'b0;
        end else begin
            note_valid <= 1'b0;

            if (edge_pulse)
                cnt <= half_period_t'(1);
            else if (!cnt_sat)
                cnt <= cnt + half_period_t'(1);

            if (capture_take) begin
                cap <= cnt;
                idx <= '0;
            end

            if (state == ST_SEARCH) begin
                if (match) begin
                    if (idx == cand_idx) begin
                        hits <= (hits == 2'd2) ? 2'd2 : hits + 2'd1;
                    end else begin
                        cand_idx <= idx;
                        hits     <= 2'd1;
                    end
                end else if (last_idx) begin
                    hits <= '0;
                end else begin
                    idx <= idx + 5'd1;
                end
            end

            // Timeout is evaluated last so it overrides a coincident DONE update.
            if (timeout_hit) begin
                note        <= '0;
                octave_up   <= 1'b0;
                octave_down <= 1'b0;
                en          <= 1'b0;
                hits        <= '0;
                note_valid  <= en;
            end else if (state == ST_DONE && hits == 2'd2 && cand_new) begin
                note        <= cand_note;
                octave_up   <= cand_up;
                octave_down <= cand_down;
                en          <= 1'b1;
                note_valid  <= 1'b1;
            end
        end
    end

    a_octave_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(octave_up && octave_down));

endmodule

// File: tb/tb_tone_decoder.sv
// Randomized and directed bench for tone_decoder against a behavioural tone model.
module tb_tone_decoder;

    localparam int unsigned TOL = 6;
    localparam int unsigned TMO = 3000;
    localparam int unsigned PSH = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tone_in = 1'b0;
    logic [3:0] note;
    logic       octave_up;
    logic       octave_down;
    logic       en;
    logic       note_valid;

    tone_decoder #(
        .TOL_SHIFT    (TOL),
        .TIMEOUT      (TMO),
        .PERIOD_SHIFT (PSH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tone_in     (tone_in),
        .note        (note),
        .octave_up   (octave_up),
        .octave_down (octave_down),
        .en          (en),
        .note_valid  (note_valid)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses = 0;
    int          exp_pulses = 0;
    int          both_hi = 0;
    int          exp_entry = -1;
    int          cand = -1;
    int          hits = 0;
    int unsigned since = TMO;
    int unsigned base_tab [7] = '{381680, 340136, 303030, 285714, 255102, 227273, 202429};

    always @(negedge clk) begin
        if (note_valid) pulses++;
        if (octave_up && octave_down) both_hi++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1);
    end

    // Reference half-period of entry e: down = 2x base, up = base/2, all scaled by 2^PSH.
    function automatic int unsigned ref_of(input int e);
        int unsigned b;
        b = base_tab[e % 7];
        case (e / 7)
            0:       return (b * 2) / (1 << PSH);
            1:       return b / (1 << PSH);
            default: return b / (2 << PSH);
        endcase
    endfunction

    function automatic int classify(input int unsigned p);
        int unsigned r;
        int unsigned d;
        for (int e = 0; e < 21; e++) begin
            r = ref_of(e);
            d = (p > r) ? p - r : r - p;
            if (d <= (r >> TOL)) return e;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".note"}, int'(note), (exp_entry >= 0) ? (exp_entry % 7) + 1 : 0);
        check({tag, ".up"}, int'(octave_up), int'(exp_entry >= 14));
        check({tag, ".down"}, int'(octave_down), int'(exp_entry >= 0 && exp_entry < 7));
        check({tag, ".en"}, int'(en), int'(exp_entry >= 0));
        check({tag, ".pulses"}, pulses, exp_pulses);
    endtask

    task automatic model_reset();
        exp_entry = -1;
        cand      = -1;
        hits      = 0;
        since     = TMO;
    endtask

    task automatic wait_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (since < TMO) begin
                since++;
                if (since == TMO) begin
                    if (exp_entry >= 0) exp_pulses++;
                    exp_entry = -1;
                    hits      = 0;
                end
            end
        end
    endtask

    task automatic model_edge(input int unsigned interval);
        int e;
        if (interval >= TMO) return;
        e = classify(interval);
        if (e < 0) begin
            hits = 0;
        end else if (e == cand) begin
            if (hits < 2) hits++;
        end else begin
            cand = e;
            hits = 1;
        end
        if (hits == 2 && cand != exp_entry) begin
            exp_entry = cand;
            exp_pulses++;
        end
    endtask

    // Toggle tone_in `interval` cycles after the previous toggle, then check once settled.
    task automatic edge_after(input int unsigned interval, input string tag);
        if (interval > since) wait_cycles(interval - since);
        tone_in = ~tone_in;
        model_edge(since);
        since = 0;
        wait_cycles(30);
        check_outputs(tag);
    endtask

    initial begin
        int          e;
        int          k;
        int unsigned r;
        int unsigned t;
        int unsigned iv;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs("reset");
        check("reset.valid", int'(note_valid), 0);

        // Steady do: locks on the third edge, then stays quiet.
        for (int i = 0; i < 6; i++) edge_after(ref_of(7), "do");
        check("do.note", int'(note), 1);
        check("do.single_pulse", pulses, 1);

        for (int i = 0; i < 5; i++) edge_after(ref_of(20), "si_up");
        for (int i = 0; i < 5; i++) edge_after(ref_of(4), "sol_down");

        // Between mi and fa tolerances: nothing matches, outputs hold.
        for (int i = 0; i < 5; i++) edge_after(294000 / (1 << PSH), "gap");

        // Silence after a steady tone.
        for (int i = 0; i < 4; i++) edge_after(ref_of(7), "pre_silence");
        wait_cycles(TMO - 10 - since);
        check_outputs("silence_before");
        wait_cycles(20);
        check_outputs("silence_after");

        // Alternating do/re never gathers two consecutive equal matches.
        for (int i = 0; i < 8; i++) edge_after(ref_of(7 + (i % 2)), "alternate");

        // Reset during a search for a late table entry.
        for (int i = 0; i < 4; i++) edge_after(ref_of(20), "pre_reset");
        if (tone_in == 1'b0) edge_after(ref_of(20), "pre_reset");
        wait_cycles(ref_of(20) - since);
        tone_in = 1'b0;
        since = 0;
        wait_cycles(8);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs("mid_search_reset");
        for (int i = 0; i < 4; i++) edge_after(ref_of(20), "post_reset");

        // Randomized bursts around table entries, with occasional arbitrary intervals.
        for (int b = 0; b < 12; b++) begin
            e = int'($urandom_range(0, 20));
            r = ref_of(e);
            t = r >> TOL;
            k = int'($urandom_range(1, 4));
            for (int i = 0; i < k; i++) begin
                if ($urandom_range(0, 5) == 0)
                    iv = $urandom_range(180, 1600);
                else
                    iv = r - t + $urandom_range(0, 2 * t);
                edge_after(iv, "rand");
            end
        end

        check("octave_exclusive", both_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
